// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory and write-back
// control around an external decoder, comparator and ALU; traps are terminal.
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic        dec_reg_write_en,
  input  logic        dec_mem_read_en,
  input  logic        dec_mem_write_en,
  input  logic        branch_taken,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] alu_result,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        retire,
  output logic        trap,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t      state;
  logic [31:0] next_pc_q;
  logic [31:0] next_pc;
  logic [31:0] imm_i;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        legal;

  assign imem_addr = pc;
  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign imm_i     = {{20{instr[31]}}, instr[31:20]};
  assign imm_b     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    legal = 1'b0;
    case (opcode)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
      7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111: legal = 1'b1;
      OP_JALR: legal = (funct3 == 3'b000);
      default: legal = 1'b0;
    endcase
  end

  // Priority: JAL, JALR, taken branch, sequential.
  always_comb begin
    next_pc = pc + 32'd4;
    if (opcode == OP_JAL)
      next_pc = pc + imm_j;
    else if (opcode == OP_JALR)
      next_pc = (rs1_data + imm_i) & ~32'd1;
    else if (opcode == OP_BRANCH && branch_taken)
      next_pc = pc + imm_b;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      next_pc_q  <= RESET_PC;
      instr      <= '0;
      instret    <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      rf_we      <= 1'b0;
      retire     <= 1'b0;
      trap       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            instr    <= imem_rdata;
            imem_req <= 1'b0;
            state    <= DECODE;
          end
        end
        DECODE: begin
          if (legal) begin
            state <= EXEC;
          end else begin
            state <= TRAP;
            trap  <= 1'b1;
          end
        end
        EXEC: begin
          dmem_addr  <= alu_result;
          dmem_wdata <= rs2_data;
          next_pc_q  <= next_pc;
          if (next_pc[1]) begin
            state <= TRAP;
            trap  <= 1'b1;
          end else if (dec_mem_read_en || dec_mem_write_en) begin
            state    <= MEM;
            dmem_req <= 1'b1;
            dmem_we  <= dec_mem_write_en;
          end else begin
            state  <= WB;
            rf_we  <= dec_reg_write_en;
            retire <= 1'b1;
          end
        end
        MEM: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            state    <= WB;
            rf_we    <= dec_reg_write_en;
            retire   <= 1'b1;
          end
        end
        WB: begin
          rf_we    <= 1'b0;
          retire   <= 1'b0;
          pc       <= next_pc_q;
          instret  <= instret + 32'd1;
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        TRAP: begin
          trap     <= 1'b1;
          imem_req <= 1'b0;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
          rf_we    <= 1'b0;
          retire   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: expected retire/trap outcomes are queued at
// fetch handshake and compared when the sequencer retires or traps.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        dec_reg_write_en, dec_mem_read_en, dec_mem_write_en;
  logic        branch_taken;
  logic [31:0] rs1_data, rs2_data, alu_result;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready;
  logic        rf_we;
  logic [31:0] pc;
  logic        retire, trap;
  logic [31:0] instret;

  core_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr),
    .dec_reg_write_en(dec_reg_write_en), .dec_mem_read_en(dec_mem_read_en),
    .dec_mem_write_en(dec_mem_write_en),
    .branch_taken(branch_taken), .rs1_data(rs1_data), .rs2_data(rs2_data), .alu_result(alu_result),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready),
    .rf_we(rf_we), .pc(pc), .retire(retire), .trap(trap), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_trap;
    logic        rf_we;
    logic [31:0] pc;
    logic [31:0] instret;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] model_pc;
  logic [31:0] model_instret;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_instret", instret, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_dmem_addr", dmem_addr, 32'h0);
    check("rst_dmem_wdata", dmem_wdata, 32'h0);
    check("rst_strobes", 32'({imem_req, dmem_req, dmem_we, rf_we, retire, trap}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_req", 32'(imem_req), 32'h0);
    @(negedge clk);
    check("fetch_req", 32'(imem_req), 32'h1);
    model_pc = 32'h0;
    model_instret = 32'h0;
  endtask

  // tkind: 0 retires, 1 traps at decode, 2 traps at execute
  task automatic run_instr(input logic [31:0] word, input logic rw, input logic mr, input logic mw,
                           input logic [31:0] alu, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic bt, input int iwait, input int dwait, input int tkind,
                           input logic [31:0] exp_pc);
    exp_t e;
    exp_t ge;
    int   fc, dc, start;
    logic done;
    imem_rdata = word;
    dec_reg_write_en = rw;
    dec_mem_read_en = mr;
    dec_mem_write_en = mw;
    alu_result = alu;
    rs1_data = rs1;
    rs2_data = rs2;
    branch_taken = bt;
    fc = 0; dc = 0; start = 0; done = 1'b0;
    ge = '{is_trap: 1'b0, rf_we: 1'b0, pc: 32'h0, instret: 32'h0, lat: 0};
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(negedge clk);
      if (start == 0) begin
        if (imem_req) begin
          if (fc == 0) check("imem_addr", imem_addr, model_pc);
          fc++;
          if (fc > iwait) begin
            imem_ready = 1'b1;
            start = cyc;
            e.is_trap = (tkind != 0);
            e.rf_we   = rw;
            e.pc      = (tkind != 0) ? model_pc : exp_pc;
            e.instret = (tkind != 0) ? model_instret : model_instret + 32'd1;
            e.lat     = (tkind == 1) ? 3 : (tkind == 2) ? 4 : (mr || mw) ? 5 + dwait : 4;
            sbq.push_back(e);
          end
        end
      end else begin
        imem_ready = 1'b0;
        if (cyc == start + 1) check("instr_latch", instr, word);
        if (dmem_req) begin
          dc++;
          check("dmem_addr", dmem_addr, alu);
          check("dmem_we", 32'(dmem_we), 32'(mw));
          if (mw && dc == 1) check("dmem_wdata", dmem_wdata, rs2);
          dmem_ready = (dc > dwait);
        end else begin
          dmem_ready = 1'b0;
        end
        if (retire || trap) begin
          if (sbq.size() > 0) ge = sbq.pop_front();
          check("latency", 32'(cyc - start + 1), 32'(ge.lat));
          check("trap", 32'(trap), 32'(ge.is_trap));
          check("retire", 32'(retire), 32'(!ge.is_trap));
          check("rf_we", 32'(rf_we), 32'(ge.rf_we && !ge.is_trap));
          if ((mr || mw) && !ge.is_trap) check("dmem_cycles", 32'(dc), 32'(dwait + 1));
          done = 1'b1;
        end else if (rf_we) begin
          check("rf_we_outside_wb", 32'(rf_we), 32'h0);
        end
      end
    end
    check("instr_done", 32'(done), 32'h1);
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    if (done && !ge.is_trap) begin
      @(negedge clk);
      check("pc_next", pc, ge.pc);
      check("instret", instret, ge.instret);
      check("retire_pulse", 32'(retire), 32'h0);
      model_pc = ge.pc;
      model_instret = ge.instret;
    end else if (done) begin
      repeat (4) begin
        @(negedge clk);
        check("trap_hold", 32'({trap, imem_req, dmem_req, retire, rf_we}), 32'h10);
        check("trap_pc", pc, ge.pc);
        check("trap_instret", instret, ge.instret);
      end
    end
  endtask

  task automatic abort_test(input logic in_mem);
    logic seen;
    seen = 1'b0;
    imem_rdata = 32'h0000A103;
    dec_reg_write_en = 1'b1;
    dec_mem_read_en = 1'b1;
    dec_mem_write_en = 1'b0;
    alu_result = 32'h300;
    dmem_ready = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clk);
      if (in_mem) begin
        seen = dmem_req;
        imem_ready = imem_req;
      end else begin
        seen = imem_req;
      end
    end
    check("abort_reached", 32'(seen), 32'h1);
    imem_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_req", 32'({imem_req, dmem_req}), 32'h0);
    check("abort_no_retire", 32'({retire, rf_we}), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = '0;
    dec_reg_write_en = 1'b0;
    dec_mem_read_en = 1'b0;
    dec_mem_write_en = 1'b0;
    branch_taken = 1'b0;
    rs1_data = '0;
    rs2_data = '0;
    alu_result = '0;
    dmem_ready = 1'b0;
    model_pc = '0;
    model_instret = '0;

    do_reset();
    run_instr(32'h00500093, 1'b1, 1'b0, 1'b0, 32'h5,   32'h0,   32'h0,        1'b0, 0, 0, 0, 32'h4);
    run_instr(32'h0000A103, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0,   32'h0,        1'b0, 2, 3, 0, 32'h8);
    run_instr(32'h0020A223, 1'b0, 1'b0, 1'b1, 32'h204, 32'h0,   32'hDEADBEEF, 1'b0, 0, 0, 0, 32'hC);
    run_instr(32'h00000013, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0,        1'b0, 0, 0, 0, 32'h10);
    run_instr(32'h00000463, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0,        1'b1, 0, 0, 0, 32'h18);
    run_instr(32'hFF9FF06F, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0,        1'b0, 1, 0, 0, 32'h10);
    run_instr(32'h00000463, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0,        1'b0, 0, 0, 0, 32'h14);
    run_instr(32'h000100E7, 1'b1, 1'b0, 1'b0, 32'h0,   32'h101, 32'h0,        1'b0, 0, 0, 0, 32'h100);
    run_instr(32'h0060006F, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0,        1'b0, 0, 0, 2, 32'h0);

    do_reset();
    abort_test(1'b0);
    do_reset();
    abort_test(1'b1);
    do_reset();
    run_instr(32'h0000007F, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 0, 1, 32'h0);

    do_reset();
    force dut.instret = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.instret;
    model_instret = 32'hFFFF_FFFF;
    run_instr(32'h00500093, 1'b1, 1'b0, 1'b0, 32'h5, 32'h0, 32'h0, 1'b0, 0, 0, 0, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the clk rising edge.
REQ-004 imem_req  output  1  instruction fetch request; imem_addr  output  32  fetch address (equals pc).
REQ-005 imem_ready  input  1  fetch complete; imem_rdata  input  32  fetched instruction word.
REQ-006 instr  output  32  latched instruction, drives the instruction decoder.
REQ-007 dec_reg_write_en, dec_mem_read_en, dec_mem_write_en  input  1 each  decoder control outputs for instr.
REQ-008 branch_taken  input  1  comparator result; rs1_data, rs2_data, alu_result  input  32 each.
REQ-009 dmem_req, dmem_we  output  1 each; dmem_addr, dmem_wdata  output  32 each; dmem_ready  input  1.
REQ-010 rf_we  output  1  register-file write strobe; pc  output  32; retire  output  1; trap  output  1; instret  output  32.

Function
REQ-011 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP; the state register is internal.
REQ-012 IDLE -> FETCH unconditionally after one cycle.
REQ-013 FETCH: imem_req=1 and imem_addr=pc, both held stable until imem_ready=1 is sampled; on that edge instr<=imem_rdata -> DECODE.
REQ-014 imem_ready is ignored outside FETCH; dmem_ready is ignored outside MEM.
REQ-015 DECODE: one cycle with no outputs asserted; illegal opcode -> TRAP, else -> EXEC.
REQ-016 Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, and 1100111 with funct3=000.
REQ-017 EXEC: dmem_addr<=alu_result and dmem_wdata<=rs2_data are latched; the next PC is computed and latched.
REQ-018 EXEC exit: target misaligned (bit1 set) -> TRAP; dec_mem_read_en or dec_mem_write_en -> MEM; otherwise -> WB.
REQ-019 Next PC is taken in this order:
- JAL: pc + imm_j, where imm_j is extracted internally from instr.
- JALR: (rs1_data + imm_i) & ~1.
- Branch with branch_taken=1: pc + imm_b.
- All other cases: pc + 4.
- All sums are 32-bit modulo 2^32.
REQ-020 MEM: dmem_req=1 and dmem_we=dec_mem_write_en, with dmem_addr and dmem_wdata held stable until dmem_ready=1 -> WB.
REQ-021 WB: one cycle with the following effects:
- rf_we=dec_reg_write_en.
- retire=1.
- pc updated to the latched next PC.
- instret incremented (wraps from 0xFFFF_FFFF to 0).
- Next state FETCH.
REQ-022 rf_we and retire are asserted only in WB, for exactly one cycle per instruction.
REQ-023 TRAP: terminal state.
- trap=1; all request and strobe outputs are 0.
- pc and instret are frozen.
- The state is left only by reset.
REQ-024 Minimum latency is 4 cycles from FETCH entry to WB for non-memory instructions and 5 cycles for loads and stores, with zero-wait ready.

Reset
REQ-025 With rst_n=0 at a clock edge:
- state<=IDLE, pc<=RESET_PC, instr<=0, instret<=0.
- dmem_addr and dmem_wdata <= 0.
- All of imem_req, dmem_req, dmem_we, rf_we, retire and trap are 0.
REQ-026 Reset asserted mid-FETCH or mid-MEM abandons the transaction.
- The request deasserts in the cycle following the reset edge.
- No retire and no rf_we are produced for the abandoned instruction.

Verification
REQ-027 Reset: hold rst_n=0 for 3 cycles, then release -> pc=0 and all outputs 0; imem_req=1 appears on the second cycle after release.
REQ-028 ADDI x1,x0,5:
- Stimulus: imem_rdata=0x00500093, imem_ready tied high.
- Response: rf_we=1 and retire=1 on the 4th cycle of the instruction; pc 0 -> 4; instret=1.
REQ-029 LW:
- Stimulus: alu_result=0x200; dmem_ready held low for 3 MEM cycles.
- Response: dmem_req high for 4 cycles with dmem_addr=0x200 and dmem_we=0; rf_we only in the following WB.
REQ-030 BEQ at pc=0x10 with offset +8:
- branch_taken=1 -> pc=0x18.
- branch_taken=0 -> pc=0x14.
- rf_we=0 in both cases.
REQ-031 JALR / JAL alignment:
- JALR with rs1_data=0x101 and imm 0 -> pc=0x100.
- JAL with offset +6 -> TRAP: trap=1, no retire, pc unchanged, imem_req=0 until reset.
REQ-032 Illegal instruction and counter wrap:
- imem_rdata=0x0000007F -> TRAP after DECODE.
- With instret preset to 0xFFFF_FFFF, one ADDI retires -> instret=0.
